// File: rtl/bev_box_engine.sv
// ---------------------------------------------------------------------------
// bev_box_engine
//
// Responder end of the beverage-system command channel. One packed command
// arrives per C_in_valid pulse. The engine reads the addressed box record from
// box memory, applies a make-drink, supply or check-date operation, writes the
// record back when the operation changes it, and returns a status word with a
// one-cycle C_out_valid strobe. Commands that arrive while an operation is in
// flight are dropped.
//
// Ports
//   clk          clock
//   rst          synchronous, active-high reset
//   C_in_valid   one-cycle command strobe (honoured only while idle)
//   C_addr       box number, sampled with C_in_valid
//   C_data_w     64-bit command word
//   C_out_valid  one-cycle response strobe
//   C_data_r     response: [1:0] err, [2] busy (live), [63:3] zero
//   mem_req      memory request, held until mem_ack
//   mem_we       1 = write, 0 = read
//   mem_addr     box index for the access
//   mem_wdata    record to write
//   mem_ack      one-cycle completion, any latency >= 1 cycle
//   mem_rdata    record, valid with mem_ack on reads
//
// Command word:  [63:52] black tea  [51:40] green tea  [39:38] action
//                [37:36] size       [35:32] month      [31:20] milk
//                [19:8]  pineapple  [7:5]   type       [4:0]   day
// Record word:   same ingredient and date positions; [39:36] and [7:5] are
//                written as zero. The record date is the expiry date.
//
// The field layout is fixed at 64 bits, so ING_W must stay at 12.
// ---------------------------------------------------------------------------
module bev_box_engine #(
  parameter int          ING_W   = 12,
  parameter int          ADDR_W  = 8,
  parameter int unsigned ING_MAX = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              C_in_valid,
  input  logic [ADDR_W-1:0] C_addr,
  input  logic [63:0]       C_data_w,
  output logic              C_out_valid,
  output logic [63:0]       C_data_r,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [63:0]       mem_rdata
);

  // -------------------------------------------------------------------------
  // Types
  // -------------------------------------------------------------------------
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    EXEC = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ACT_MAKE   = 2'd0,
    ACT_SUPPLY = 2'd1,
    ACT_CHECK  = 2'd2,
    ACT_RSVD   = 2'd3
  } action_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_EXPIRED  = 2'd1,
    ERR_NO_ING   = 2'd2,
    ERR_OVERFLOW = 2'd3
  } err_e;

  typedef struct packed {
    logic [ING_W-1:0] black_tea;
    logic [ING_W-1:0] green_tea;
    action_e          action;
    logic [1:0]       size;
    logic [3:0]       month;
    logic [ING_W-1:0] milk;
    logic [ING_W-1:0] pineapple;
    logic [2:0]       drink_type;
    logic [4:0]       day;
  } cmd_t;

  typedef struct packed {
    logic [ING_W-1:0] black_tea;
    logic [ING_W-1:0] green_tea;
    logic [3:0]       rsv_hi;
    logic [3:0]       month;
    logic [ING_W-1:0] milk;
    logic [ING_W-1:0] pineapple;
    logic [2:0]       rsv_lo;
    logic [4:0]       day;
  } rec_t;

  // Saturation ceiling at the two widths it is compared/assigned at.
  localparam logic [ING_W:0]   ING_MAX_X = ING_MAX[ING_W:0];
  localparam logic [ING_W-1:0] ING_MAX_F = ING_MAX[ING_W-1:0];

  localparam int N_ING = 4;

  // -------------------------------------------------------------------------
  // State and captured operands
  // -------------------------------------------------------------------------
  state_e state;
  cmd_t   cmd_q;      // command latched in IDLE
  rec_t   rec_q;      // record latched on the read acknowledge
  err_e   err_q;      // result code, reported in the response cycle

  // Ingredient vectors, index 3 = black tea ... index 0 = pineapple.
  logic [N_ING-1:0][ING_W-1:0] rec_ing;
  logic [N_ING-1:0][ING_W-1:0] cmd_ing;
  logic [N_ING-1:0][ING_W-1:0] need;
  logic [N_ING-1:0][ING_W:0]   sum;
  logic [N_ING-1:0][ING_W-1:0] new_ing;

  logic       expired;
  logic       short_any;
  logic       ovf_any;
  err_e       exec_err;
  logic       exec_wr;
  logic [3:0] new_month;
  logic [4:0] new_day;
  rec_t       exec_rec;
  logic       busy;
  logic [1:0] err_field;

  assign rec_ing = {rec_q.black_tea, rec_q.green_tea, rec_q.milk, rec_q.pineapple};
  assign cmd_ing = {cmd_q.black_tea, cmd_q.green_tea, cmd_q.milk, cmd_q.pineapple};

  // Lexicographic (month, day) compare; an equal date is still good.
  assign expired = (cmd_q.month > rec_q.month) ||
                   ((cmd_q.month == rec_q.month) && (cmd_q.day > rec_q.day));

  // -------------------------------------------------------------------------
  // Per-ingredient arithmetic shared by make and supply
  // -------------------------------------------------------------------------
  // NOTE: every signal driven from an always_comb gets a default assignment at
  // the top of the block so that no path leaves it unassigned (no latch).
  always_comb begin
    need      = '0;
    sum       = '0;
    short_any = 1'b0;
    ovf_any   = 1'b0;
    for (int i = 0; i < N_ING; i++) begin
      // Make deltas are zero or negative, so the amount needed is the
      // two's-complement negation; 0x800 negates to 2048, which still fits.
      need[i] = -cmd_ing[i];
      // Supply sums carry one extra bit so overflow is visible before clamp.
      sum[i]  = {1'b0, rec_ing[i]} + {1'b0, cmd_ing[i]};
      if (rec_ing[i] < need[i]) begin
        short_any = 1'b1;
      end
      if (sum[i] > ING_MAX_X) begin
        ovf_any = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Operation decode: result code, write-back decision and new record
  // -------------------------------------------------------------------------
  always_comb begin
    exec_err  = ERR_OK;
    exec_wr   = 1'b0;
    new_ing   = rec_ing;
    new_month = rec_q.month;
    new_day   = rec_q.day;
    case (cmd_q.action)
      ACT_MAKE: begin
        // Expiry outranks a shortage; the stock only moves on success.
        if (expired) begin
          exec_err = ERR_EXPIRED;
        end else if (short_any) begin
          exec_err = ERR_NO_ING;
        end else begin
          exec_wr = 1'b1;
          for (int i = 0; i < N_ING; i++) begin
            new_ing[i] = rec_ing[i] - need[i];
          end
        end
      end
      ACT_SUPPLY: begin
        // Supply always lands, clamped, and restamps the expiry date.
        exec_wr   = 1'b1;
        new_month = cmd_q.month;
        new_day   = cmd_q.day;
        if (ovf_any) begin
          exec_err = ERR_OVERFLOW;
        end
        for (int i = 0; i < N_ING; i++) begin
          new_ing[i] = (sum[i] > ING_MAX_X) ? ING_MAX_F : sum[i][ING_W-1:0];
        end
      end
      ACT_CHECK: begin
        if (expired) begin
          exec_err = ERR_EXPIRED;
        end
      end
      default: begin
        // Reserved action: the read still happens, nothing else does.
      end
    endcase
  end

  assign exec_rec = '{
    black_tea: new_ing[3],
    green_tea: new_ing[2],
    rsv_hi:    4'd0,
    month:     new_month,
    milk:      new_ing[1],
    pineapple: new_ing[0],
    rsv_lo:    3'd0,
    day:       new_day
  };

  // -------------------------------------------------------------------------
  // Control FSM with registered outputs
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset abandons any outstanding access; a late mem_ack lands in IDLE,
      // where it is ignored.
      state       <= IDLE;
      C_out_valid <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cmd_q       <= '0;
      rec_q       <= '0;
      err_q       <= ERR_OK;
    end else begin
      C_out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (C_in_valid) begin
            cmd_q    <= cmd_t'(C_data_w);
            mem_addr <= C_addr;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            state    <= RD;
          end
        end
        RD: begin
          // mem_rdata is only meaningful alongside the read acknowledge.
          if (mem_ack) begin
            rec_q   <= rec_t'(mem_rdata);
            mem_req <= 1'b0;
            state   <= EXEC;
          end
        end
        EXEC: begin
          err_q <= exec_err;
          if (exec_wr) begin
            mem_wdata <= exec_rec;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            state     <= WR;
          end else begin
            C_out_valid <= 1'b1;
            state       <= RESP;
          end
        end
        WR: begin
          if (mem_ack) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            C_out_valid <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          // C_out_valid was raised on entry; it drops on this edge. A command
          // strobe seen here is dropped because the engine is still busy.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Response word
  // -------------------------------------------------------------------------
  assign busy      = (state != IDLE);
  assign err_field = C_out_valid ? 2'(err_q) : 2'b00;
  assign C_data_r  = {61'd0, busy, err_field};

  // Fields carried by the formats but not used by any operation.
  logic unused_fields;
  assign unused_fields = ^{cmd_q.size, cmd_q.drink_type, rec_q.rsv_hi, rec_q.rsv_lo};

endmodule

// File: tb/tb_bev_box_engine.sv
// ---------------------------------------------------------------------------
// tb_bev_box_engine
//
// Self-checking bench for bev_box_engine. A behavioural box memory answers
// mem_req after a programmable number of cycles; a reference model computes
// the expected status, write-back and latency from the command and record
// fields with plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_bev_box_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        C_in_valid;
  logic [7:0]  C_addr;
  logic [63:0] C_data_w;
  logic        C_out_valid;
  logic [63:0] C_data_r;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack   = 1'b0;
  logic [63:0] mem_rdata = '0;

  int n_checks = 0;
  int n_pass   = 0;

  bev_box_engine #(.ING_W(12), .ADDR_W(8), .ING_MAX(4095)) dut (
    .clk        (clk),
    .rst        (rst),
    .C_in_valid (C_in_valid),
    .C_addr     (C_addr),
    .C_data_w   (C_data_w),
    .C_out_valid(C_out_valid),
    .C_data_r   (C_data_r),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Box memory model: sees a request on a falling edge, raises mem_ack
  // ack_delay falling edges later for exactly one cycle.
  // -------------------------------------------------------------------------
  logic [63:0] mem [256];
  int          ack_delay  = 1;
  int          rd_cnt     = 0;
  int          wr_cnt     = 0;
  int          resp_total = 0;
  logic [7:0]  last_raddr = '0;
  bit          m_pend     = 1'b0;
  int          m_cnt      = 0;
  bit          m_we       = 1'b0;
  logic [7:0]  m_addr     = '0;
  logic [63:0] m_wdata    = '0;

  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack   = 1'b0;
      mem_rdata = {$urandom, $urandom};
    end else if (m_pend) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_pend  = 1'b0;
        mem_ack = 1'b1;
        if (m_we) mem[m_addr] = m_wdata;
        else      mem_rdata   = mem[m_addr];
      end
    end else if (mem_req) begin
      m_pend  = 1'b1;
      m_cnt   = ack_delay;
      m_we    = mem_we;
      m_addr  = mem_addr;
      m_wdata = mem_wdata;
      if (mem_we) wr_cnt = wr_cnt + 1;
      else begin
        rd_cnt     = rd_cnt + 1;
        last_raddr = mem_addr;
      end
    end
  end

  always @(negedge clk) begin
    if (C_out_valid) resp_total = resp_total + 1;
  end

  // -------------------------------------------------------------------------
  // Field builders and reference model
  // -------------------------------------------------------------------------
  function automatic logic [63:0] mk_rec(input int bt, input int gt, input int month,
                                         input int milk, input int pine, input int day);
    logic [63:0] r;
    r = '0;
    r[63:52] = 12'(bt);
    r[51:40] = 12'(gt);
    r[35:32] = 4'(month);
    r[31:20] = 12'(milk);
    r[19:8]  = 12'(pine);
    r[4:0]   = 5'(day);
    return r;
  endfunction

  function automatic logic [63:0] mk_cmd(input int bt, input int gt, input int act,
                                         input int month, input int milk, input int pine,
                                         input int day);
    logic [63:0] c;
    c = mk_rec(bt, gt, month, milk, pine, day);
    c[39:38] = 2'(act);
    return c;
  endfunction

  function automatic void ref_op(input logic [63:0] rec, input logic [63:0] cmd,
                                 output logic [1:0] err, output bit wr,
                                 output logic [63:0] nrec);
    int pos[4] = '{52, 40, 20, 8};
    int r[4];
    int c[4];
    int n[4];
    int rdate, cdate, month, day;
    bit expired, short_any;
    rdate   = int'(rec[35:32]) * 32 + int'(rec[4:0]);
    cdate   = int'(cmd[35:32]) * 32 + int'(cmd[4:0]);
    expired = cdate > rdate;
    month   = int'(rec[35:32]);
    day     = int'(rec[4:0]);
    short_any = 1'b0;
    err = 2'd0;
    wr  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r[i] = int'(rec[pos[i] +: 12]);
      c[i] = int'(cmd[pos[i] +: 12]);
      n[i] = r[i];
    end
    case (cmd[39:38])
      2'd0: begin
        for (int i = 0; i < 4; i++)
          if (r[i] < (4096 - c[i]) % 4096) short_any = 1'b1;
        if (expired)        err = 2'd1;
        else if (short_any) err = 2'd2;
        else begin
          wr = 1'b1;
          for (int i = 0; i < 4; i++) n[i] = r[i] - (4096 - c[i]) % 4096;
        end
      end
      2'd1: begin
        wr    = 1'b1;
        month = int'(cmd[35:32]);
        day   = int'(cmd[4:0]);
        for (int i = 0; i < 4; i++) begin
          n[i] = r[i] + c[i];
          if (n[i] > 4095) begin
            n[i] = 4095;
            err  = 2'd3;
          end
        end
      end
      2'd2: err = expired ? 2'd1 : 2'd0;
      default: err = 2'd0;
    endcase
    nrec = '0;
    for (int i = 0; i < 4; i++) nrec[pos[i] +: 12] = 12'(n[i]);
    nrec[35:32] = 4'(month);
    nrec[4:0]   = 5'(day);
  endfunction

  // Issue one command and wait (bounded) for its response. lat counts cycles
  // from the strobe cycle to the response cycle.
  task automatic send_cmd(input logic [7:0] addr, input logic [63:0] cmd,
                          output int lat, output logic [63:0] word, output bit got);
    @(negedge clk);
    C_addr     = addr;
    C_data_w   = cmd;
    C_in_valid = 1'b1;
    @(negedge clk);
    C_in_valid = 1'b0;
    lat  = 1;
    got  = 1'b0;
    word = '0;
    while (!got && lat < 200) begin
      if (C_out_valid) begin
        got  = 1'b1;
        word = C_data_r;
      end else begin
        @(negedge clk);
        lat = lat + 1;
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Tests
  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (C_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", C_out_valid); else n_pass++;
    n_checks++; if (C_data_r !== 64'd0) $display("FAIL reset_data_r: got %h want 0", C_data_r); else n_pass++;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", mem_req); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we); else n_pass++;
    n_checks++; if (mem_addr !== 8'd0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else n_pass++;
    n_checks++; if (mem_wdata !== 64'd0) $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_make();
    int lat, wr0;
    bit got;
    logic [63:0] word, want;
    ack_delay = 1;
    mem[5] = mk_rec(12'h960, 12'h111, 12, 12'h222, 12'h333, 31);
    want   = mk_rec(12'h870, 12'h111, 12, 12'h222, 12'h333, 31);
    wr0 = wr_cnt;
    send_cmd(8'd5, mk_cmd(12'hF10, 0, 0, 3, 0, 0, 15), lat, word, got);
    n_checks++; if (!got) $display("FAIL make_resp: no response within %0d cycles", lat); else n_pass++;
    n_checks++; if (lat !== 6) $display("FAIL make_latency: got %0d want 6", lat); else n_pass++;
    n_checks++; if (word !== 64'h4) $display("FAIL make_status: got %h want 4", word); else n_pass++;
    n_checks++; if (mem[5] !== want) $display("FAIL make_record: got %h want %h", mem[5], want); else n_pass++;
    n_checks++; if (wr_cnt - wr0 !== 1) $display("FAIL make_writes: got %0d want 1", wr_cnt - wr0); else n_pass++;
  endtask

  task automatic test_make_errors();
    int lat, wr0;
    bit got;
    logic [63:0] word, rec, cmd;
    cmd = mk_cmd(12'hF10, 0, 0, 3, 12'hF10, 0, 15);
    // Record one day older than the command date: expired beats everything.
    rec = mk_rec(12'h960, 0, 3, 12'h500, 0, 14);
    mem[6] = rec;
    wr0 = wr_cnt;
    send_cmd(8'd6, cmd, lat, word, got);
    n_checks++; if (word[1:0] !== 2'd1 || !got) $display("FAIL make_expired_err: got %0d want 1", word[1:0]); else n_pass++;
    n_checks++; if (lat !== 4) $display("FAIL make_expired_latency: got %0d want 4", lat); else n_pass++;
    n_checks++; if (wr_cnt !== wr0 || mem[6] !== rec) $display("FAIL make_expired_nowrite: writes %0d record %h", wr_cnt - wr0, mem[6]); else n_pass++;
    // Same date is fresh; milk 0x010 cannot cover a need of 0x0F0.
    rec = mk_rec(12'h960, 0, 3, 12'h010, 0, 15);
    mem[6] = rec;
    send_cmd(8'd6, cmd, lat, word, got);
    n_checks++; if (word[1:0] !== 2'd2 || !got) $display("FAIL make_short_err: got %0d want 2", word[1:0]); else n_pass++;
    n_checks++; if (wr_cnt !== wr0 || mem[6] !== rec) $display("FAIL make_short_nowrite: writes %0d record %h", wr_cnt - wr0, mem[6]); else n_pass++;
  endtask

  task automatic test_supply();
    int lat;
    bit got;
    logic [63:0] word, want;
    mem[7] = mk_rec(12'hF00, 12'h123, 2, 12'h456, 12'h789, 10) | 64'h0000_00F0_0000_00E0;
    want   = mk_rec(12'hFFF, 12'h124, 6, 12'h457, 12'h78A, 1);
    send_cmd(8'd7, mk_cmd(12'h200, 1, 1, 6, 1, 1, 1), lat, word, got);
    n_checks++; if (word[1:0] !== 2'd3 || !got) $display("FAIL supply_err: got %0d want 3", word[1:0]); else n_pass++;
    n_checks++; if (lat !== 6) $display("FAIL supply_latency: got %0d want 6", lat); else n_pass++;
    n_checks++; if (mem[7] !== want) $display("FAIL supply_record: got %h want %h", mem[7], want); else n_pass++;
  endtask

  task automatic test_check_date();
    int lat, wr0;
    bit got;
    logic [63:0] word;
    mem[8] = mk_rec(1, 2, 4, 3, 4, 30);
    wr0 = wr_cnt;
    send_cmd(8'd8, mk_cmd(0, 0, 2, 5, 0, 0, 1), lat, word, got);
    n_checks++; if (word[1:0] !== 2'd1 || !got) $display("FAIL check_late_err: got %0d want 1", word[1:0]); else n_pass++;
    send_cmd(8'd8, mk_cmd(0, 0, 2, 4, 0, 0, 30), lat, word, got);
    n_checks++; if (word[1:0] !== 2'd0 || !got) $display("FAIL check_same_err: got %0d want 0", word[1:0]); else n_pass++;
    n_checks++; if (lat !== 4) $display("FAIL check_latency: got %0d want 4", lat); else n_pass++;
    n_checks++; if (wr_cnt !== wr0) $display("FAIL check_nowrite: got %0d writes want 0", wr_cnt - wr0); else n_pass++;
  endtask

  task automatic test_busy_drop();
    int rd0, wr0, resp0, n;
    bit got;
    logic [63:0] word, rec;
    rec = mk_rec(12'h100, 12'h100, 4, 12'h100, 12'h100, 30);
    mem[20] = rec;
    mem[21] = rec;
    mem[22] = rec;
    ack_delay = 10;
    @(negedge clk);
    rd0 = rd_cnt; wr0 = wr_cnt; resp0 = resp_total;
    C_addr = 8'd20; C_data_w = mk_cmd(0, 0, 2, 5, 0, 0, 1); C_in_valid = 1'b1;
    @(negedge clk);
    C_in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (C_data_r[2] !== 1'b1) $display("FAIL busy_flag: got %b want 1", C_data_r[2]); else n_pass++;
    C_addr = 8'd21; C_data_w = mk_cmd(1, 1, 1, 9, 1, 1, 9); C_in_valid = 1'b1;
    @(negedge clk);
    C_in_valid = 1'b0;
    n = 0; got = 1'b0; word = '0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (C_out_valid) begin got = 1'b1; word = C_data_r; end
    end
    n_checks++; if (!got || word[1:0] !== 2'd1) $display("FAIL busy_first_resp: got valid %b err %0d want 1 1", got, word[1:0]); else n_pass++;
    // A strobe during the response cycle must also be dropped.
    C_addr = 8'd22; C_data_w = mk_cmd(1, 1, 1, 9, 1, 1, 9); C_in_valid = 1'b1;
    @(negedge clk);
    C_in_valid = 1'b0;
    repeat (30) @(negedge clk);
    n_checks++; if (resp_total - resp0 !== 1) $display("FAIL busy_resp_count: got %0d want 1", resp_total - resp0); else n_pass++;
    n_checks++; if (rd_cnt - rd0 !== 1 || last_raddr !== 8'd20) $display("FAIL busy_reads: got %0d last %0d want 1 20", rd_cnt - rd0, last_raddr); else n_pass++;
    n_checks++; if (wr_cnt !== wr0) $display("FAIL busy_writes: got %0d want 0", wr_cnt - wr0); else n_pass++;
    n_checks++; if (C_data_r[2] !== 1'b0 || mem_req !== 1'b0) $display("FAIL busy_idle: busy %b req %b want 0 0", C_data_r[2], mem_req); else n_pass++;
    ack_delay = 1;
  endtask

  task automatic test_reset_in_wr();
    int resp0, n;
    ack_delay = 8;
    mem[50] = mk_rec(12'h100, 12'h100, 4, 12'h100, 12'h100, 30);
    @(negedge clk);
    resp0 = resp_total;
    C_addr = 8'd50; C_data_w = mk_cmd(1, 1, 1, 9, 1, 1, 9); C_in_valid = 1'b1;
    @(negedge clk);
    C_in_valid = 1'b0;
    n = 0;
    while (!(mem_req && mem_we) && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++; if (!(mem_req && mem_we)) $display("FAIL rstwr_reach_wr: req %b we %b want 1 1", mem_req, mem_we); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) $display("FAIL rstwr_req: req %b we %b want 0 0", mem_req, mem_we); else n_pass++;
    n_checks++; if (C_out_valid !== 1'b0 || C_data_r !== 64'd0) $display("FAIL rstwr_idle: valid %b data %h want 0 0", C_out_valid, C_data_r); else n_pass++;
    rst = 1'b0;
    // The abandoned write is still acknowledged later by the memory.
    repeat (30) @(negedge clk);
    n_checks++; if (resp_total !== resp0) $display("FAIL rstwr_no_resp: got %0d responses want 0", resp_total - resp0); else n_pass++;
    n_checks++; if (mem_req !== 1'b0 || C_data_r[2] !== 1'b0) $display("FAIL rstwr_quiet: req %b busy %b want 0 0", mem_req, C_data_r[2]); else n_pass++;
    ack_delay = 1;
  endtask

  task automatic test_random();
    logic [63:0] shadow [16];
    logic [63:0] cmd, word, nrec;
    logic [1:0]  err;
    bit          wr, got;
    int          a, act, lat, wr0, need, exp_lat;
    for (int i = 0; i < 16; i++) begin
      shadow[i]   = {$urandom, $urandom};
      mem[100 + i] = shadow[i];
    end
    for (int it = 0; it < 40; it++) begin
      a   = int'($urandom_range(0, 15));
      act = int'($urandom_range(0, 3));
      cmd = {$urandom, $urandom};
      cmd[39:38] = 2'(act);
      cmd[35:32] = 4'($urandom_range(1, 12));
      cmd[4:0]   = 5'($urandom_range(1, 31));
      if ($urandom_range(0, 3) == 0) begin
        cmd[35:32] = shadow[a][35:32];
        cmd[4:0]   = shadow[a][4:0];
      end
      if (act == 0) begin
        for (int k = 0; k < 4; k++) begin
          need = int'($urandom_range(0, 12'h400));
          if ($urandom_range(0, 7) == 0) need = 2048;
          cmd[(k == 0 ? 52 : k == 1 ? 40 : k == 2 ? 20 : 8) +: 12] = 12'((4096 - need) % 4096);
        end
      end else if (act == 1) begin
        cmd[63:52] = 12'($urandom_range(0, 12'h7FF));
        cmd[51:40] = 12'($urandom_range(0, 12'h7FF));
        cmd[31:20] = 12'($urandom_range(0, 12'h7FF));
        cmd[19:8]  = 12'($urandom_range(0, 12'h7FF));
      end
      ref_op(shadow[a], cmd, err, wr, nrec);
      if (wr) shadow[a] = nrec;
      ack_delay = int'($urandom_range(1, 4));
      exp_lat   = wr ? 4 + 2 * ack_delay : 3 + ack_delay;
      wr0 = wr_cnt;
      send_cmd(8'(100 + a), cmd, lat, word, got);
      n_checks++; if (!got || word !== {61'd0, 1'b1, err}) $display("FAIL rand_status[%0d]: got %h want %h", it, word, {61'd0, 1'b1, err}); else n_pass++;
      n_checks++; if (lat !== exp_lat) $display("FAIL rand_latency[%0d]: got %0d want %0d", it, lat, exp_lat); else n_pass++;
      n_checks++; if (wr_cnt - wr0 !== int'(wr)) $display("FAIL rand_writes[%0d]: got %0d want %0d", it, wr_cnt - wr0, wr); else n_pass++;
      n_checks++; if (mem[100 + a] !== shadow[a]) $display("FAIL rand_record[%0d]: got %h want %h", it, mem[100 + a], shadow[a]); else n_pass++;
    end
    ack_delay = 1;
  endtask

  // -------------------------------------------------------------------------
  // Sequence
  // -------------------------------------------------------------------------
  initial begin
    rst        = 1'b1;
    C_in_valid = 1'b0;
    C_addr     = '0;
    C_data_w   = '0;
    test_reset();
    test_make();
    test_make_errors();
    test_supply();
    test_check_date();
    test_busy_drop();
    test_reset_in_wr();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: still running at %0t, %0d/%0d checks passed", $time, n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bev_box_engine.md
Name: bev_box_engine

Overview:
- Responder end of the beverage-system command channel.
- Accepts one packed command per C_in_valid pulse from the ordering front end. For that box it reads the stored record from box memory, runs a make-drink, supply or check-date operation, and writes the record back when required.
- Returns a status word with a one-cycle C_out_valid.
- Sits between the front end and the box-memory port (DRAM model or bridge).

Parameters:
- ING_W, 12, width of each ingredient amount (unsigned stock, two's-complement delta).
- ADDR_W, 8, box index width.
- ING_MAX, 4095, saturation ceiling for stock, equal to 2**ING_W-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- C_in_valid  in  1  one-cycle command strobe.
- C_addr  in  ADDR_W  box number, sampled with C_in_valid.
- C_data_w  in  64  command. Fields:
  - [63:52] black tea, [51:40] green tea, [31:20] milk, [19:8] pineapple.
  - [39:38] action: 0 make, 1 supply, 2 check date, 3 reserved.
  - [37:36] size, [35:32] month, [7:5] type, [4:0] day.
- C_out_valid  out  1  one-cycle response strobe.
- C_data_r  out  64  response:
  - [1:0] err: 0 ok, 1 expired, 2 no ingredient, 3 supply overflow.
  - [2] busy, live at all times.
  - [63:3] zero.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  box index.
- mem_wdata  out  64  record to write.
- mem_ack  in  1  one-cycle completion; latency of 1 or more cycles, unbounded.
- mem_rdata  in  64  record, valid with mem_ack on reads.

Behaviour:
- Record format: [63:52] black tea, [51:40] green tea, [35:32] expiry month, [31:20] milk, [19:8] pineapple, [4:0] expiry day. Bits [39:36] and [7:5] are written as 0.
- Reset (rst high at a clk edge): C_out_valid=0, C_data_r=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, state=IDLE. This applies mid-operation too: an outstanding access is abandoned, any late mem_ack is ignored, and no response is issued.
- FSM states: IDLE, RD, EXEC, WR, RESP.
  - IDLE: on C_in_valid, latch C_addr and C_data_w, assert mem_req with mem_we=0, go to RD.
  - Any C_in_valid arriving outside IDLE is dropped silently; busy=1 in all states except IDLE.
  - RD: hold mem_req, mem_addr and mem_we until mem_ack. Then latch mem_rdata, drop mem_req, go to EXEC.
  - EXEC (one cycle): compute err and the new record.
  - From EXEC: if a write is needed, go to WR with mem_req=1 and mem_we=1; otherwise go to RESP.
  - WR: hold mem_req, mem_we and mem_wdata until mem_ack, then go to RESP.
  - RESP: C_out_valid=1 and C_data_r[1:0]=err for exactly one cycle, then IDLE. A C_in_valid in that same cycle is dropped.
- Expiry test: a record is expired iff (cmd month > rec month) or (months equal and cmd day > rec day). Equal date is not expired.
- Make (action 0):
  - Each command ingredient field is a 12-bit two's-complement delta of 0 or less; need = -delta.
  - Error priority: expired gives err=1, else any rec field < need gives err=2, else err=0.
  - Write-back only when err=0: each field becomes rec - need, and the date is unchanged.
- Supply (action 1):
  - Command fields are unsigned additions.
  - Per field, sum = rec + add computed in ING_W+1 bits. If sum > ING_MAX, the field becomes ING_MAX and err=3; otherwise the field becomes sum.
  - Always written back; expiry month/day are replaced by the command date.
  - Expiry is not checked.
- Check date (action 2): err=1 if expired, else 0. No write.
- Reserved action (3): err=0, no write. The read is still performed.
- Latency from C_in_valid to C_out_valid is 3 + read wait for no-write paths, and 4 + read wait + write wait for write paths. With a mem_ack of 1 cycle, these are 4 and 6 cycles respectively.
- mem_rdata is only sampled in RD on mem_ack. mem_ack outside RD/WR is ignored.

Test Plan:
- Make with record BT=0x960, expiry 12/31. Command 0xF10 in the BT field (-240), date 3/15, mem_ack 1 cycle -> C_out_valid 6 cycles after C_in_valid with err=0; mem_wdata BT=0x870, other fields unchanged.
- Make with record date 3/14, command date 3/15 -> err=1, no write (mem_we never 1). Same command with record date 3/15 and milk=0x010 against a milk need of 0x0F0 -> err=2, no write.
- Supply to BT=0xF00 with add 0x200, other adds 0x001, date 6/1 -> err=3; written BT=0xFFF, others +1, expiry 6/1.
- Check date: record 4/30, command 5/1 -> err=1. Command 4/30 -> err=0. No memory write in either case.
- Second C_in_valid while in RD (busy=1), with mem_ack delayed 10 cycles -> second command dropped; exactly one C_out_valid and one read issued.
- rst asserted during WR with mem_req high -> next cycle mem_req=0, C_out_valid=0, state IDLE; a mem_ack arriving afterwards causes no response.
